pll_clock_gen: RTL and testbench

//   Synthesizable, counter-based stand-in for the vendor PLL inside the clocking block.
//   - Runs from the single reference clock inclk0.
//   - Derives four clocks:
//       c0: system clock.
//       c1: system clock delayed by a quarter period.
//       c2: TMDS pixel clock.
//       c3: TMDS x5 serializer clock.
//   - Asserts locked once its outputs are declared stable.
//   - Drives the system and HDMI/TMDS clock domains.

---
 rtl/pll_clock_gen.sv | 83 ++++++++
 tb/tb_pll_clock_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/pll_clock_gen.sv
// Counter-based stand-in for the vendor PLL: derives system, quadrature, pixel and x5 serializer
// clocks from inclk0 as registered outputs, plus a lock indicator.
module pll_clock_gen #(
   parameter int unsigned DIV0        = 8,
   parameter int unsigned DIV3        = 2,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic inclk0,
   input  logic nreset_in,
   output logic c0,
   output logic c1,
   output logic c2,
   output logic c3,
   output logic locked
);

   localparam int unsigned W0 = (DIV0 > 1) ? $clog2(DIV0) : 1;
   localparam int unsigned W3 = (DIV3 > 1) ? $clog2(DIV3) : 1;
   localparam int unsigned WL = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

   localparam logic [W0-1:0] CNT0_LAST = W0'(DIV0 - 1);
   localparam logic [W0-1:0] CNT0_HALF = W0'(DIV0 / 2);
   localparam logic [W0-1:0] CNT0_Q1   = W0'(DIV0 / 4);
   localparam logic [W0-1:0] CNT0_Q3   = W0'((3 * DIV0) / 4);
   localparam logic [W3-1:0] CNT3_LAST = W3'(DIV3 - 1);
   localparam logic [W3-1:0] CNT3_HALF = W3'(DIV3 / 2);
   localparam logic [WL-1:0] LOCK_MAX  = WL'(LOCK_CYCLES);
   localparam logic [WL-1:0] LOCK_LAST = WL'(LOCK_CYCLES - 1);

   if ((DIV0 % 4) != 0 || DIV0 < 4) begin : g_bad_div0
      $error("pll_clock_gen: DIV0 must be a multiple of 4 and >= 4");
   end
   if ((DIV3 % 2) != 0 || DIV3 < 2) begin : g_bad_div3
      $error("pll_clock_gen: DIV3 must be even and >= 2");
   end
   if (LOCK_CYCLES < 1) begin : g_bad_lock
      $error("pll_clock_gen: LOCK_CYCLES must be >= 1");
   end

   logic [W0-1:0] cnt0;
   logic [W3-1:0] cnt3;
   logic [2:0]    cnt5;
   logic [WL-1:0] lock_cnt;
   logic [3:0]    half_idx;

   // Half-period index of the pixel clock, counted in c3 half-periods (0..9).
   always_comb begin
      half_idx = {cnt5, (cnt3 >= CNT3_HALF)};
   end

   always_ff @(posedge inclk0 or negedge nreset_in) begin
      if (!nreset_in) begin
         cnt0     <= '0;
         cnt3     <= '0;
         cnt5     <= '0;
         lock_cnt <= '0;
         c0       <= 1'b0;
         c1       <= 1'b0;
         c2       <= 1'b0;
         c3       <= 1'b0;
         locked   <= 1'b0;
      end else begin
         cnt0 <= (cnt0 == CNT0_LAST) ? '0 : cnt0 + W0'(1);
         c0   <= (cnt0 < CNT0_HALF);
         c1   <= (cnt0 >= CNT0_Q1) && (cnt0 < CNT0_Q3);

         cnt3 <= (cnt3 == CNT3_LAST) ? '0 : cnt3 + W3'(1);
         c3   <= (cnt3 < CNT3_HALF);
         if (cnt3 == CNT3_LAST) begin
            cnt5 <= (cnt5 == 3'd4) ? '0 : cnt5 + 3'd1;
         end
         c2 <= (half_idx < 4'd5);

         if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + WL'(1);
         end
         if (lock_cnt == LOCK_LAST) begin
            locked <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pll_clock_gen.sv
// Directed bench for pll_clock_gen: default divisors and DIV0=4/DIV3=4 instances share clock and reset,
// outputs are checked each edge against hand-written per-phase patterns.
module tb_pll_clock_gen;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic a_c0, a_c1, a_c2, a_c3, a_locked;
   logic b_c0, b_c1, b_c2, b_c3, b_locked;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   int unsigned edge_k     = 0;

   // Bit i = expected level on edge number (i+1) of each period after reset release.
   logic [7:0]  pat_a_c0 = 8'b0000_1111;
   logic [7:0]  pat_a_c1 = 8'b0011_1100;
   logic [9:0]  pat_a_c2 = 10'b00000_11111;
   logic [1:0]  pat_a_c3 = 2'b01;
   logic [3:0]  pat_b_c0 = 4'b0011;
   logic [3:0]  pat_b_c1 = 4'b0110;
   logic [19:0] pat_b_c2 = 20'h003FF;
   logic [3:0]  pat_b_c3 = 4'b0011;

   always #5 clk = ~clk;

   pll_clock_gen #(.DIV0(8), .DIV3(2), .LOCK_CYCLES(16)) dut_a (
      .inclk0    (clk),
      .nreset_in (rst_n),
      .c0        (a_c0),
      .c1        (a_c1),
      .c2        (a_c2),
      .c3        (a_c3),
      .locked    (a_locked)
   );

   pll_clock_gen #(.DIV0(4), .DIV3(4), .LOCK_CYCLES(16)) dut_b (
      .inclk0    (clk),
      .nreset_in (rst_n),
      .c0        (b_c0),
      .c1        (b_c1),
      .c2        (b_c2),
      .c3        (b_c3),
      .locked    (b_locked)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s edge %0d: got %b expected %b", tag, edge_k, got, exp);
      end
   endtask

   task automatic check_zero();
      chk("a_c0_rst", a_c0, 1'b0);
      chk("a_c1_rst", a_c1, 1'b0);
      chk("a_c2_rst", a_c2, 1'b0);
      chk("a_c3_rst", a_c3, 1'b0);
      chk("a_locked_rst", a_locked, 1'b0);
      chk("b_c0_rst", b_c0, 1'b0);
      chk("b_c1_rst", b_c1, 1'b0);
      chk("b_c2_rst", b_c2, 1'b0);
      chk("b_c3_rst", b_c3, 1'b0);
      chk("b_locked_rst", b_locked, 1'b0);
   endtask

   task automatic step_check();
      int unsigned p;
      @(posedge clk);
      @(negedge clk);
      edge_k++;
      p = edge_k - 1;
      chk("a_c0", a_c0, pat_a_c0[p % 8]);
      chk("a_c1", a_c1, pat_a_c1[p % 8]);
      chk("a_c2", a_c2, pat_a_c2[p % 10]);
      chk("a_c3", a_c3, pat_a_c3[p % 2]);
      chk("a_locked", a_locked, (edge_k >= 16));
      chk("b_c0", b_c0, pat_b_c0[p % 4]);
      chk("b_c1", b_c1, pat_b_c1[p % 4]);
      chk("b_c2", b_c2, pat_b_c2[p % 20]);
      chk("b_c3", b_c3, pat_b_c3[p % 4]);
      chk("b_locked", b_locked, (edge_k >= 16));
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check_zero();

      rst_n  = 1'b1;
      edge_k = 0;
      repeat (1030) step_check();

      // Asynchronous reset between edges must clear everything immediately.
      #2 rst_n = 1'b0;
      #1 check_zero();
      repeat (3) @(negedge clk);
      check_zero();

      rst_n  = 1'b1;
      edge_k = 0;
      repeat (40) step_check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
